// File: rtl/cdc_pkg.sv
// Shared types and helpers for the clka/destination handshake crossing.
// Used by cdc_tx_handshake (optional timeout via CDC_TX_TIMEOUT_EN) and
// by the destination-side receiver.
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } cdc_state_e;

   localparam int SYNC_STAGES_DEF = 2;

   // Bits needed to hold values 0..v-1 (returns 0 for v <= 1)
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/toggle_sync.sv
// N-stage flop synchroniser for a level/toggle signal entering clk's domain.
module toggle_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   // Shift the asynchronous input through N flops; cleared on rst
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[N-2:0], d_i};
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdc_tx_handshake.sv
// Source-domain end of a multi-bit toggle-handshake CDC.
// A word is captured onto bus_data, announced one cycle later by toggling
// req_tgl, and the next word is refused until the synchronised ack_tgl
// level matches req_tgl again.
// Optional: define CDC_TX_TIMEOUT_EN to add the sticky err_timeout output,
// set after TIMEOUT cycles spent waiting for an ack.
module cdc_tx_handshake
   import cdc_pkg::*;
#(
   parameter int SIZE        = 32,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = 1024
) (
   input  logic            clka,
   input  logic            rsta,
   input  logic [SIZE-1:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic [SIZE-1:0] bus_data,
   output logic            req_tgl,
   input  logic            ack_tgl,
   output logic            done_p,
`ifdef CDC_TX_TIMEOUT_EN
   output logic            err_timeout,
`endif
   output logic            busy
);

   cdc_state_e      state_q;
   logic [SIZE-1:0] bus_data_q;
   logic            req_q;
   logic            ready_q;
   logic            done_q;
   logic            busy_q;
   logic            ack_s;

   // The only consumer of ack_tgl: everything else sees ack_s
   toggle_sync #(.N(SYNC_STAGES)) u_ack_sync (
      .clk (clka),
      .rst (rsta),
      .d_i (ack_tgl),
      .q_o (ack_s)
   );

   // Handshake FSM; all outputs registered. IDLE never looks at ack_s, so a
   // stale ack level left over from a reset cannot fake a completion.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q    <= IDLE;
         bus_data_q <= '0;
         req_q      <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (din_valid) begin
                  bus_data_q <= din;
                  state_q    <= LOAD;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            // bus_data has now been stable a full cycle; announce it
            LOAD: begin
               req_q   <= ~req_q;
               state_q <= WAIT;
            end
            // Level compare, so the 1-bit toggle may wrap forever
            WAIT: begin
               if (ack_s == req_q) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CDC_TX_TIMEOUT_EN
   localparam int CW = clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt_q;
   logic          err_q;

   // Count WAIT cycles; flag (sticky until reset) once TIMEOUT have elapsed.
   // The transfer itself keeps waiting.
   always_ff @(posedge clka) begin
      if (rsta) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (state_q == LOAD) begin
            wait_cnt_q <= '0;
         end else if (state_q == WAIT) begin
            if (wait_cnt_q != CW'(TIMEOUT)) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == CW'(TIMEOUT - 1)) err_q <= 1'b1;
         end
      end
   end

   assign err_timeout = err_q;
`endif

   assign din_ready = ready_q;
   assign bus_data  = bus_data_q;
   assign req_tgl   = req_q;
   assign done_p    = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_cdc_tx_handshake.sv
// Directed bench for cdc_tx_handshake. The destination is modelled as a
// DLY-flop loopback of req_tgl onto ack_tgl (reset together with the DUT),
// or a manually driven ack level.
module tb_cdc_tx_handshake;

   localparam int SIZE = 32;
   localparam int SYNC = 2;
   localparam int DLY  = 3;
   localparam int TMO  = 16;

   logic            clka = 1'b0;
   logic            rsta = 1'b1;
   logic [SIZE-1:0] din = '0;
   logic            din_valid = 1'b0;
   logic            din_ready;
   logic [SIZE-1:0] bus_data;
   logic            req_tgl;
   logic            ack_tgl;
   logic            done_p;
   logic            busy;
`ifdef CDC_TX_TIMEOUT_EN
   logic            err_timeout;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [DLY-1:0] dly_q;
   logic           loop_en = 1'b1;
   logic           ack_man = 1'b0;

   cdc_tx_handshake #(.SIZE(SIZE), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
      .clka        (clka),
      .rsta        (rsta),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .bus_data    (bus_data),
      .req_tgl     (req_tgl),
      .ack_tgl     (ack_tgl),
      .done_p      (done_p),
`ifdef CDC_TX_TIMEOUT_EN
      .err_timeout (err_timeout),
`endif
      .busy        (busy)
   );

   always #5 clka = ~clka;

   // Destination model: ack follows req after DLY clka cycles
   always @(posedge clka) begin
      if (rsta) dly_q <= '0;
      else      dly_q <= {dly_q[DLY-2:0], req_tgl};
   end
   assign ack_tgl = loop_en ? dly_q[DLY-1] : ack_man;

   // Monitors: accept count, req_tgl history, bus_data changes while busy
   int          n_acc = 0;
   int          n_bus_viol = 0;
   logic        req_prev = 1'b0;
   logic        busy_prev = 1'b0;
   logic [31:0] bus_prev = '0;
   logic        req_hist[$];

   always @(posedge clka) begin
      if (!rsta && din_valid && din_ready) n_acc <= n_acc + 1;
   end

   always @(negedge clka) begin
      if (req_tgl !== req_prev) req_hist.push_back(req_tgl);
      if (busy && busy_prev && bus_data !== bus_prev) n_bus_viol <= n_bus_viol + 1;
      req_prev  <= req_tgl;
      busy_prev <= busy;
      bus_prev  <= bus_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic do_reset();
      rsta = 1'b1;
      step();
      step();
      rsta = 1'b0;
      #2;
      req_hist.delete();
   endtask

   int          k;
   int          acc0;
   logic        seen;
   logic [31:0] w;

   initial begin
      // ---- reset / idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         chk("idle_ready", din_ready, 1);
         chk("idle_req",   req_tgl,   0);
         chk("idle_bus",   bus_data,  0);
         chk("idle_busy",  busy,      0);
         chk("idle_done",  done_p,    0);
         step();
      end

      // ---- single word, looped-back ack
      din = 32'hDEADBEEF; din_valid = 1'b1;
      step();                          // accept edge
      din_valid = 1'b0; din = '0;
      chk("acc_bus",   bus_data,  32'hDEADBEEF);
      chk("acc_ready", din_ready, 0);
      chk("acc_busy",  busy,      1);
      chk("acc_req",   req_tgl,   0);
      step();                          // LOAD -> toggle
      chk("load_req",  req_tgl,   1);
      chk("load_bus",  bus_data,  32'hDEADBEEF);
      // ack arrives DLY cycles later, SYNC more to sync, 1 to register done
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (done_p) begin k = i; break; end
         chk("wait_ready", din_ready, 0);
      end
      chk("done_lat", k, DLY + SYNC + 1);
      chk("done_ready", din_ready, 1);
      chk("done_busy",  busy,      0);
      step();
      chk("done_pulse", done_p, 0);
      chk("post_ready", din_ready, 1);

      // ---- 4 back-to-back words, din_valid held high
      do_reset();
      acc0 = n_acc;
      w = 1; din = w; din_valid = 1'b1;
      for (int c = 0; c < 200 && w <= 4; c++) begin
         seen = din_ready;
         step();
         if (seen) begin
            chk("b2b_bus", bus_data, w);
            w = w + 1;
            din = w;
            if (w > 4) din_valid = 1'b0;
         end
      end
      for (int c = 0; c < 50 && busy; c++) step();
      step();
      chk("b2b_idle", busy, 0);
      chk("b2b_accepts", n_acc - acc0, 4);
      chk("b2b_nreq", req_hist.size(), 4);
      if (req_hist.size() == 4) begin
         chk("b2b_req0", req_hist[0], 1);
         chk("b2b_req1", req_hist[1], 0);
         chk("b2b_req2", req_hist[2], 1);
         chk("b2b_req3", req_hist[3], 0);
      end
      chk("b2b_bus_stable", n_bus_viol, 0);

      // ---- din churn during WAIT is ignored
      do_reset();
      acc0 = n_acc;
      din = 32'hA5A50001; din_valid = 1'b1;
      step();
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         din = 32'h1000 + c;
         if (done_p) begin seen = 1'b1; din_valid = 1'b0; break; end
         chk("churn_bus", bus_data, 32'hA5A50001);
         step();
      end
      chk("churn_done", seen, 1);
      step();
      chk("churn_accepts", n_acc - acc0, 1);
      chk("churn_bus_end", bus_data, 32'hA5A50001);

      // ---- reset while waiting with req=1, ack=0
      do_reset();
      loop_en = 1'b0; ack_man = 1'b0;
      din = 32'h12345678; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step();
      step();
      chk("rw_req_before", req_tgl, 1);
      chk("rw_busy_before", busy, 1);
      rsta = 1'b1;
      step();
      rsta = 1'b0;
      chk("rw_req",   req_tgl,   0);
      chk("rw_ready", din_ready, 1);
      chk("rw_busy",  busy,      0);
      chk("rw_bus",   bus_data,  0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (done_p) seen = 1'b1;
         step();
      end
      chk("rw_no_done", seen, 0);

`ifdef CDC_TX_TIMEOUT_EN
      // ---- timeout: ack withheld, flag after TMO WAIT cycles, sticky
      do_reset();
      loop_en = 1'b0; ack_man = 1'b0;
      chk("to_reset", err_timeout, 0);
      din = 32'hCAFEF00D; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step();                          // now in WAIT
      for (int c = 0; c < TMO - 1; c++) step();
      chk("to_before", err_timeout, 0);
      step();
      chk("to_set", err_timeout, 1);
      chk("to_still_busy", busy, 1);
      for (int c = 0; c < 5; c++) step();
      chk("to_sticky", err_timeout, 1);
      ack_man = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (done_p) begin seen = 1'b1; break; end
      end
      chk("to_late_done", seen, 1);
      chk("to_after_done", err_timeout, 1);
      ack_man = 1'b0;
      do_reset();
      chk("to_cleared", err_timeout, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
